commit_trace_monitor: RTL and testbench
=======================================

Name: commit_trace_monitor

Overview:
- Sits directly downstream of the pipelined core's writeback/commit outputs (o_insn_vld, o_ctrl, o_mispred, o_pc_debug).
- Counts cycles, retired instructions, retired control transfers and mispredictions.
- Buffers the PCs of retired control-transfer instructions in a FIFO, drained through a valid/ready stream for an off-chip logger or debug UART.
- Counters are read through a select/data port.

Parameters:
- DEPTH, 16, trace FIFO entries; power of two, 2..256.
- CNT_W, 32, width of every event counter.

Ports:
- i_clk  in  1  system clock, same clock as the core.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  1 = count/capture; 0 = freeze counters and block FIFO pushes.
- i_insn_vld  in  1  valid instruction committed this cycle (core o_insn_vld).
- i_ctrl  in  1  committed instruction is a branch/jump (core o_ctrl).
- i_mispred  in  1  misprediction flag (core o_mispred, already registered).
- i_pc_debug  in  32  committed PC (core o_pc_debug).
- i_cnt_clear  in  1  synchronous clear of all counters.
- i_trace_flush  in  1  synchronous empty of the trace FIFO.
- i_cnt_sel  in  3  counter select: 0 cycles, 1 retired, 2 ctrl, 3 mispred, 4 dropped, 5 fifo level; 6–7 read 0.
- o_cnt_data  out  CNT_W  selected counter, combinational from registers.
- o_trace_valid  out  1  FIFO head entry valid.
- o_trace_pc  out  32  head entry PC.
- o_trace_mispred  out  1  head entry mispredict flag.
- i_trace_ready  in  1  consumer accepts head entry.

Behaviour:
- Reset (i_reset=0, async):
  - all counters = 0; FIFO empty; read/write pointers = 0.
  - o_trace_valid = 0, o_trace_pc = 0, o_trace_mispred = 0, o_cnt_data = 0.
  - Release is sampled on the next rising edge.
- Counters, when i_enable=1, each edge:
  - cycles += 1.
  - retired += i_insn_vld.
  - ctrl += (i_insn_vld & i_ctrl).
  - mispred += i_mispred. This counter does not depend on i_insn_vld.
- Counter wrap and freeze: all counters wrap modulo 2^CNT_W, with no saturation. When i_enable=0, counters hold.
- i_cnt_clear=1: every counter is 0 after the edge. Events in the clear cycle are not counted. i_cnt_clear has priority over increment.
- Push condition: i_enable & i_insn_vld & i_ctrl.
  - Entry = {i_mispred, i_pc_debug}, with i_mispred sampled in the same cycle.
- Pop condition: o_trace_valid & i_trace_ready.
- Latency: a push into an empty FIFO makes o_trace_valid=1 on the next cycle. There is no bypass.
- FIFO output: o_trace_pc/o_trace_mispred always show the entry at the read pointer. They are stable while valid & !ready.
- Full without pop: the push is discarded and dropped += 1 (wraps). FIFO contents are unchanged.
- Full with simultaneous pop: both occur. Level stays DEPTH and nothing is dropped.
- Empty with simultaneous push: only the push takes effect, because valid=0 means no pop.
- Pointers are log2(DEPTH)+1 bits with natural wrap. full = MSBs differ and the rest are equal. level = wptr - rptr.
- i_trace_flush=1: after the edge, pointers are equal and o_trace_valid=0. A push in the same cycle is discarded and is not counted as dropped. Flush has priority over push and pop.
- i_cnt_clear does not affect the FIFO. i_trace_flush does not affect counters, except that the fifo level reads 0.
- Asserting reset mid-stream discards all FIFO contents immediately; o_trace_valid falls asynchronously.

Test Plan:
- Reset then 10 cycles with i_enable=1 and no commits: sel0=10, sel1=0, o_trace_valid=0 throughout.
- 5 commits (insn_vld=1), of which 2 have ctrl=1 with pc 0x0000_0040 and 0x0000_0080 (second with mispred=1), ready=0:
  - sel1=5, sel2=2, sel3=1, sel5=2.
  - Head is 0x40 with mispred=0 from the cycle after the first push.
  - After one ready pulse, head is 0x80 with mispred=1.
- DEPTH=16, ready=0, 20 ctrl commits with PCs 0x100+4k: sel5=16, sel4=4. Draining yields PCs 0x100..0x13C in order, then valid=0.
- FIFO full, push and ready=1 in the same cycle: sel4 unchanged, sel5 stays 16, the new PC appears after the other 15 on drain.
- i_enable=0 for 7 cycles during commits: counters are unchanged and there are no pushes. i_cnt_clear together with a commit: all counters read 0 next cycle.
- Assert i_reset=0 asynchronously with 3 entries queued: o_trace_valid=0 before the next edge; all sel reads are 0 after release.

Source files
------------

// File: rtl/commit_trace_monitor.sv
// commit_trace_monitor
// Watches the core's commit stream. It counts cycles, retired instructions,
// retired control transfers, mispredictions and dropped trace pushes. The PCs
// of retired control transfers go into a FIFO, which a valid/ready stream
// drains. A select/data port reads the counters back.
module commit_trace_monitor #(
  parameter int DEPTH = 16,  // trace entries, power of two, 2..256
  parameter int CNT_W = 32   // counter width, must exceed log2(DEPTH)+1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_insn_vld,
  input  logic             i_ctrl,
  input  logic             i_mispred,
  input  logic [31:0]      i_pc_debug,
  input  logic             i_cnt_clear,
  input  logic             i_trace_flush,
  input  logic [2:0]       i_cnt_sel,
  output logic [CNT_W-1:0] o_cnt_data,
  output logic             o_trace_valid,
  output logic [31:0]      o_trace_pc,
  output logic             o_trace_mispred,
  input  logic             i_trace_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0]    PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [PW-1:0]    PTR_ZERO = {PW{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Trace storage: {mispred, pc}
  logic [32:0]      mem_q [DEPTH];

  // Pointers carry one extra wrap bit so full and empty can be told apart
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;

  // Event counters
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] ctl_q, ctl_d;
  logic [CNT_W-1:0] mis_q, mis_d;
  logic [CNT_W-1:0] drp_q, drp_d;

  logic             push_req_s;
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             do_push_s;
  logic             drop_s;
  logic [PW-1:0]    level_s;
  logic [32:0]      head_s;

  // FIFO status and the push/pop/drop decisions for this cycle
  always_comb begin
    push_req_s = i_enable & i_insn_vld & i_ctrl;
    empty_s    = (wptr_q == rptr_q);
    full_s     = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                 (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
    level_s    = wptr_q - rptr_q;
    // valid=0 can never pop, so an empty FIFO only sees the push
    pop_s      = ~empty_s & i_trace_ready;
    // When full, a pop in the same cycle frees the slot the push takes
    do_push_s  = push_req_s & (~full_s | pop_s) & ~i_trace_flush;
    // A push lost to a flush is not counted as dropped
    drop_s     = push_req_s & full_s & ~pop_s & ~i_trace_flush;
  end

  // Pointer next state: flush wins over push and pop
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (i_trace_flush) begin
      rptr_d = wptr_q;
    end else begin
      if (do_push_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
    end
  end

  // Pointer registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wptr_q <= PTR_ZERO;
      rptr_q <= PTR_ZERO;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Trace storage. It is cleared on reset so the head reads 0 while empty.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 33'd0;
      end
    end else if (do_push_s) begin
      mem_q[wptr_q[AW-1:0]] <= {i_mispred, i_pc_debug};
    end
  end

  // Counter next state: clear wins over increment, enable=0 freezes
  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    ctl_d = ctl_q;
    mis_d = mis_q;
    drp_d = drp_q;
    if (i_cnt_clear) begin
      cyc_d = CNT_ZERO;
      ret_d = CNT_ZERO;
      ctl_d = CNT_ZERO;
      mis_d = CNT_ZERO;
      drp_d = CNT_ZERO;
    end else if (i_enable) begin
      cyc_d = cyc_q + CNT_ONE;
      ret_d = ret_q + (i_insn_vld ? CNT_ONE : CNT_ZERO);
      ctl_d = ctl_q + ((i_insn_vld & i_ctrl) ? CNT_ONE : CNT_ZERO);
      // The mispredict flag is already registered in the core and is not
      // qualified by insn_vld
      mis_d = mis_q + (i_mispred ? CNT_ONE : CNT_ZERO);
      drp_d = drp_q + (drop_s ? CNT_ONE : CNT_ZERO);
    end else begin
      cyc_d = cyc_q;
      ret_d = ret_q;
      ctl_d = ctl_q;
      mis_d = mis_q;
      drp_d = drp_q;
    end
  end

  // Counter registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cyc_q <= CNT_ZERO;
      ret_q <= CNT_ZERO;
      ctl_q <= CNT_ZERO;
      mis_q <= CNT_ZERO;
      drp_q <= CNT_ZERO;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
      ctl_q <= ctl_d;
      mis_q <= mis_d;
      drp_q <= drp_d;
    end
  end

  // Counter read mux. Selects 6 and 7 read as zero.
  always_comb begin
    o_cnt_data = CNT_ZERO;
    case (i_cnt_sel)
      3'd0:    o_cnt_data = cyc_q;
      3'd1:    o_cnt_data = ret_q;
      3'd2:    o_cnt_data = ctl_q;
      3'd3:    o_cnt_data = mis_q;
      3'd4:    o_cnt_data = drp_q;
      3'd5:    o_cnt_data = {{(CNT_W-PW){1'b0}}, level_s};
      default: o_cnt_data = CNT_ZERO;
    endcase
  end

  // Head of the FIFO. It comes straight from the registers, so valid drops
  // together with the asynchronous pointer reset.
  always_comb begin
    head_s          = mem_q[rptr_q[AW-1:0]];
    o_trace_valid   = ~empty_s;
    o_trace_pc      = head_s[31:0];
    o_trace_mispred = head_s[32];
  end

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Directed bench for commit_trace_monitor: a vector table plus hand-written
// multi-cycle sequences for fill/drop, full-with-pop and async reset.
`timescale 1ns/1ps
module tb_commit_trace_monitor;

  logic        clk;
  logic        i_reset;
  logic        i_enable;
  logic        i_insn_vld;
  logic        i_ctrl;
  logic        i_mispred;
  logic [31:0] i_pc_debug;
  logic        i_cnt_clear;
  logic        i_trace_flush;
  logic [2:0]  i_cnt_sel;
  logic [31:0] o_cnt_data;
  logic        o_trace_valid;
  logic [31:0] o_trace_pc;
  logic        o_trace_mispred;
  logic        i_trace_ready;

  int n_tests = 0;
  int n_fail  = 0;

  commit_trace_monitor #(.DEPTH(16), .CNT_W(32)) dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_enable        (i_enable),
    .i_insn_vld      (i_insn_vld),
    .i_ctrl          (i_ctrl),
    .i_mispred       (i_mispred),
    .i_pc_debug      (i_pc_debug),
    .i_cnt_clear     (i_cnt_clear),
    .i_trace_flush   (i_trace_flush),
    .i_cnt_sel       (i_cnt_sel),
    .o_cnt_data      (o_cnt_data),
    .o_trace_valid   (o_trace_valid),
    .o_trace_pc      (o_trace_pc),
    .o_trace_mispred (o_trace_mispred),
    .i_trace_ready   (i_trace_ready)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        en, vld, ctrl, mp;
    logic [31:0] pc;
    logic        clr, fl, rdy;
    logic [2:0]  sel;
    logic [31:0] ecnt;
    logic        ev, ech;
    logic [31:0] epc;
    logic        emp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [2:0] sel, input logic [31:0] exp, input string name);
    i_cnt_sel = sel;
    #1;
    chk($sformatf("%s sel%0d", name, sel), 64'(o_cnt_data), 64'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic vld, input logic ctrl, input logic mp,
                       input logic [31:0] pc, input logic rdy);
    i_enable      = en;
    i_insn_vld    = vld;
    i_ctrl        = ctrl;
    i_mispred     = mp;
    i_pc_debug    = pc;
    i_trace_ready = rdy;
    i_cnt_clear   = 1'b0;
    i_trace_flush = 1'b0;
  endtask

  task automatic addv(input logic en, input logic vld, input logic ctrl, input logic mp,
                      input logic [31:0] pc, input logic clr, input logic fl, input logic rdy,
                      input logic [2:0] sel, input logic [31:0] ecnt,
                      input logic ev, input logic ech, input logic [31:0] epc, input logic emp);
    vec_t t;
    t.en = en; t.vld = vld; t.ctrl = ctrl; t.mp = mp; t.pc = pc;
    t.clr = clr; t.fl = fl; t.rdy = rdy; t.sel = sel; t.ecnt = ecnt;
    t.ev = ev; t.ech = ech; t.epc = epc; t.emp = emp;
    vecs.push_back(t);
  endtask

  initial begin
    // Table: state before first row is cycles=10, all else 0, FIFO empty.
    //    en   vld  ctrl mp   pc            clr  fl   rdy  sel   exp_cnt  ev   ech  epc           emp
    addv(1'b1,1'b1,1'b0,1'b0,32'h0000_0010,1'b0,1'b0,1'b0,3'd1,32'd1,   1'b0,1'b1,32'h0,        1'b0);
    addv(1'b1,1'b1,1'b1,1'b0,32'h0000_0040,1'b0,1'b0,1'b0,3'd2,32'd1,   1'b1,1'b1,32'h0000_0040,1'b0);
    addv(1'b1,1'b1,1'b0,1'b0,32'h0000_0044,1'b0,1'b0,1'b0,3'd0,32'd13,  1'b1,1'b1,32'h0000_0040,1'b0);
    addv(1'b1,1'b1,1'b1,1'b1,32'h0000_0080,1'b0,1'b0,1'b0,3'd3,32'd1,   1'b1,1'b1,32'h0000_0040,1'b0);
    addv(1'b1,1'b1,1'b0,1'b0,32'h0000_0084,1'b0,1'b0,1'b0,3'd5,32'd2,   1'b1,1'b1,32'h0000_0040,1'b0);
    addv(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,3'd1,32'd5,   1'b1,1'b1,32'h0000_0040,1'b0);
    addv(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,3'd2,32'd2,   1'b1,1'b1,32'h0000_0040,1'b0);
    addv(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,3'd5,32'd1,   1'b1,1'b1,32'h0000_0080,1'b1);
    addv(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,3'd3,32'd1,   1'b1,1'b1,32'h0000_0080,1'b1);
    addv(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,3'd5,32'd0,   1'b0,1'b1,32'h0,        1'b0);
    // mispred without insn_vld still counts
    addv(1'b1,1'b0,1'b0,1'b1,32'h0,        1'b0,1'b0,1'b0,3'd3,32'd2,   1'b0,1'b1,32'h0,        1'b0);
    // seven frozen cycles with control commits: nothing counted, nothing pushed
    addv(1'b0,1'b1,1'b1,1'b1,32'h0000_0200,1'b0,1'b0,1'b0,3'd0,32'd21,  1'b0,1'b1,32'h0,        1'b0);
    addv(1'b0,1'b1,1'b1,1'b1,32'h0000_0200,1'b0,1'b0,1'b0,3'd1,32'd5,   1'b0,1'b1,32'h0,        1'b0);
    addv(1'b0,1'b1,1'b1,1'b1,32'h0000_0200,1'b0,1'b0,1'b0,3'd2,32'd2,   1'b0,1'b1,32'h0,        1'b0);
    addv(1'b0,1'b1,1'b1,1'b1,32'h0000_0200,1'b0,1'b0,1'b0,3'd3,32'd2,   1'b0,1'b1,32'h0,        1'b0);
    addv(1'b0,1'b1,1'b1,1'b1,32'h0000_0200,1'b0,1'b0,1'b0,3'd5,32'd0,   1'b0,1'b1,32'h0,        1'b0);
    addv(1'b0,1'b1,1'b1,1'b1,32'h0000_0200,1'b0,1'b0,1'b0,3'd4,32'd0,   1'b0,1'b1,32'h0,        1'b0);
    addv(1'b0,1'b1,1'b1,1'b1,32'h0000_0200,1'b0,1'b0,1'b0,3'd0,32'd21,  1'b0,1'b1,32'h0,        1'b0);
    // clear with a commit: counters zero, FIFO still takes the push
    addv(1'b1,1'b1,1'b1,1'b1,32'h0000_0300,1'b1,1'b0,1'b0,3'd0,32'd0,   1'b1,1'b1,32'h0000_0300,1'b1);
    addv(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,3'd1,32'd0,   1'b1,1'b1,32'h0000_0300,1'b1);
    addv(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,3'd0,32'd2,   1'b1,1'b1,32'h0000_0300,1'b1);
    addv(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,3'd5,32'd0,   1'b0,1'b1,32'h0,        1'b0);
    addv(1'b1,1'b1,1'b1,1'b0,32'h0000_0400,1'b0,1'b0,1'b0,3'd2,32'd1,   1'b1,1'b1,32'h0000_0400,1'b0);
    // flush with a push: FIFO empties, push discarded, not dropped, still counted
    addv(1'b1,1'b1,1'b1,1'b0,32'h0000_0404,1'b0,1'b1,1'b0,3'd4,32'd0,   1'b0,1'b0,32'h0,        1'b0);
    addv(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,3'd2,32'd2,   1'b0,1'b0,32'h0,        1'b0);
    addv(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,3'd5,32'd0,   1'b0,1'b0,32'h0,        1'b0);

    // Reset state
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    i_cnt_sel = 3'd0;
    i_reset   = 1'b0;
    step();
    chk("reset valid", 64'(o_trace_valid), 64'd0);
    chk("reset pc", 64'(o_trace_pc), 64'd0);
    chk("reset mispred", 64'(o_trace_mispred), 64'd0);
    for (int s = 0; s < 8; s++) rd(3'(s), 32'd0, "reset");
    i_reset = 1'b1;

    // Ten idle enabled cycles
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("idle%0d valid", c), 64'(o_trace_valid), 64'd0);
    end
    rd(3'd0, 32'd10, "idle");
    rd(3'd1, 32'd0, "idle");

    // Vector table
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].vld, vecs[i].ctrl, vecs[i].mp, vecs[i].pc, vecs[i].rdy);
      i_cnt_clear   = vecs[i].clr;
      i_trace_flush = vecs[i].fl;
      step();
      chk($sformatf("row%0d valid", i), 64'(o_trace_valid), 64'(vecs[i].ev));
      if (vecs[i].ech) begin
        chk($sformatf("row%0d pc", i), 64'(o_trace_pc), 64'(vecs[i].epc));
        chk($sformatf("row%0d mispred", i), 64'(o_trace_mispred), 64'(vecs[i].emp));
      end
      rd(vecs[i].sel, vecs[i].ecnt, $sformatf("row%0d", i));
    end

    // 20 control commits into an empty 16-deep FIFO: 4 dropped
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100 + 32'(4 * k), 1'b0);
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    rd(3'd5, 32'd16, "fill");
    rd(3'd4, 32'd4, "fill");
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d valid", k), 64'(o_trace_valid), 64'd1);
      chk($sformatf("drain%0d pc", k), 64'(o_trace_pc), 64'(32'h100 + 32'(4 * k)));
      i_trace_ready = 1'b1;
      step();
    end
    i_trace_ready = 1'b0;
    chk("drain end valid", 64'(o_trace_valid), 64'd0);
    rd(3'd4, 32'd4, "drain end");

    // Full with simultaneous push and pop
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h500 + 32'(4 * k), 1'b0);
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    rd(3'd5, 32'd16, "full");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h600, 1'b1);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    rd(3'd4, 32'd4, "full+pop");
    rd(3'd5, 32'd16, "full+pop");
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("fp%0d valid", k), 64'(o_trace_valid), 64'd1);
      chk($sformatf("fp%0d pc", k), 64'(o_trace_pc),
          64'((k < 15) ? (32'h504 + 32'(4 * k)) : 32'h600));
      i_trace_ready = 1'b1;
      step();
    end
    i_trace_ready = 1'b0;
    chk("fp end valid", 64'(o_trace_valid), 64'd0);

    // Asynchronous reset with three entries queued
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h700 + 32'(4 * k), 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    rd(3'd5, 32'd3, "pre-reset");
    chk("pre-reset valid", 64'(o_trace_valid), 64'd1);
    #1 i_reset = 1'b0;
    #1;
    chk("async valid", 64'(o_trace_valid), 64'd0);
    chk("async pc", 64'(o_trace_pc), 64'd0);
    chk("async mispred", 64'(o_trace_mispred), 64'd0);
    i_reset = 1'b1;
    for (int s = 0; s < 6; s++) rd(3'(s), 32'd0, "post-reset");
    step();
    rd(3'd0, 32'd0, "post-reset frozen");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
